pic_host_sequencer: RTL
=======================

Name: pic_host_sequencer

Overview:
- CPU-side initiator for the 8259-compatible PIC: drives its bus (CS/WR/RD/A0/data) and INTA.
- On request it programs the PIC with ICW1..ICW4 plus an OCW1 mask.
- Answers the PIC's INT with an 8086-style two-pulse INTA cycle and captures the vector byte.
- Issues non-specific EOI (OCW2) on request; used as the host model/bridge in PIC subsystem tops and benches.

Parameters:
- WR_PULSE, 2, cycles wr_n is held low per register write (>=1)
- INTA_PULSE, 2, cycles int_ack_n is held low per INTA pulse (>=1)
- INTA_GAP, 1, cycles int_ack_n is high between the two INTA pulses (>=1)

Ports:
- clk  input  1  system clock; all logic rising-edge
- reset  input  1  synchronous, active-high reset
- start_init  input  1  one-cycle pulse: begin the init sequence
- cfg_icw1  input  8  ICW1 byte; bit4 is forced to 1 on the bus
- cfg_icw2  input  8  ICW2 byte (vector base)
- cfg_icw3  input  8  ICW3 byte (cascade configuration)
- cfg_icw4  input  8  ICW4 byte
- cfg_mask  input  8  OCW1 mask written last
- eoi_req  input  1  pulse: write OCW2 = 8'h20 (non-specific EOI)
- pic_int  input  1  INT from PIC, same clock domain
- cs_n  output  1  PIC chip select, active low
- wr_n  output  1  write strobe, active low
- rd_n  output  1  read strobe; held at 1 (status reads out of scope)
- a0  output  1  PIC address bit
- data_out  output  8  byte driven to PIC
- data_oe  output  1  data_out valid/driven
- data_in  input  8  PIC data bus during INTA
- int_ack_n  output  1  INTA to PIC, active low
- vector  output  8  last captured vector
- vector_valid  output  1  one-cycle pulse when vector updates
- init_done  output  1  high after init completes
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values, and on reset asserted at any time including mid-cycle:
  - cs_n=1, wr_n=1, rd_n=1, int_ack_n=1, a0=0, data_out=0, data_oe=0
  - vector=0, vector_valid=0, init_done=0, busy=0, state=IDLE, pending EOI cleared
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, A1_LOW, A_GAP, A2_LOW, A_END.
- Write bus cycle:
  - W_SETUP: 1 cycle; cs_n=0, data_oe=1, a0/data_out valid, wr_n=1.
  - W_STROBE: WR_PULSE cycles; wr_n=0.
  - W_HOLD: 1 cycle; wr_n=1 with cs_n, a0 and data still held.
  - Then cs_n=1, data_oe=0 and the next step begins.
  - Total = WR_PULSE+2 cycles per write.
- Init sequence, latched at start_init:
  - ICW1 (a0=0, data=cfg_icw1|8'h10)
  - ICW2 (a0=1)
  - ICW3 (a0=1) only if cfg_icw1[1]==0
  - ICW4 (a0=1) only if cfg_icw1[0]==1
  - OCW1 (a0=1, cfg_mask)
  - Writes are back-to-back: next W_SETUP directly follows W_HOLD.
  - init_done clears on the ICW1 setup cycle and sets in the cycle after the OCW1 W_HOLD.
- EOI: single write, a0=0, data=8'h20.
  - eoi_req received while busy is latched as one pending EOI; further requests while one is pending are merged.
- INTA (only when init_done=1, state IDLE, pic_int=1):
  - A1_LOW: INTA_PULSE cycles, int_ack_n=0.
  - A_GAP: INTA_GAP cycles, int_ack_n=1.
  - A2_LOW: INTA_PULSE cycles, int_ack_n=0; data_in sampled into vector on the last A2_LOW cycle.
  - A_END: 1 cycle, int_ack_n=1, vector_valid=1.
  - cs_n, wr_n and data_oe are inactive throughout; INTA sequences are never interrupted except by reset.
- Arbitration in IDLE (highest first): start_init, pending/current EOI, pic_int.
- start_init while busy is ignored; the current operation completes.
- pic_int is re-evaluated only in IDLE, so INT still high after A_END triggers a new INTA sequence 1 cycle later (in IDLE).

Optional Feature:
- Macro: PIC_HOST_AUTO_EOI_EN.
- Defined: each A_END sets the pending-EOI flag, so an OCW2 8'h20 write begins in the next IDLE cycle ahead of pic_int.
- Undefined: EOI is written only on eoi_req.

Test Plan:
- Init with defaults, cfg_icw1=8'h11, icw2=8'h40, icw3=8'h00, icw4=8'h01, mask=8'hF0 -> writes (a0,data) = (0,11),(1,40),(1,00),(1,01),(1,F0); each has wr_n low 2 cycles; init_done rises exactly 20 cycles after the first W_SETUP.
- cfg_icw1=8'h12 (single, no ICW4) -> only (0,12),(1,icw2),(1,mask) written; ICW3/ICW4 skipped.
- After init, pic_int=1 with data_in=8'h45 during 2nd pulse -> int_ack_n low 2, high 1, low 2; vector=8'h45 with vector_valid pulse one cycle after pulse 2 ends.
- eoi_req during INTA sequence -> INTA completes unchanged, then write (0,20) follows immediately; a second eoi_req while pending produces one write only.
- reset asserted in W_STROBE of ICW2 -> next cycle all strobes inactive, init_done=0, busy=0; later start_init restarts from ICW1.
- With PIC_HOST_AUTO_EOI_EN: INTA with pic_int held high -> (0,20) write occurs before the second INTA sequence.

Source files
------------

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: 8259 host initiator (ICW/OCW1 init, two-pulse INTA, EOI); define PIC_HOST_AUTO_EOI_EN to queue an EOI after every INTA
module pic_host_sequencer #(
    parameter int WR_PULSE   = 2,
    parameter int INTA_PULSE = 2,
    parameter int INTA_GAP   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_init,
    input  logic [7:0] cfg_icw1,
    input  logic [7:0] cfg_icw2,
    input  logic [7:0] cfg_icw3,
    input  logic [7:0] cfg_icw4,
    input  logic [7:0] cfg_mask,
    input  logic       eoi_req,
    input  logic       pic_int,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output logic       int_ack_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       init_done,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, A1_LOW, A_GAP, A2_LOW, A_END} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic [2:0] step;
    logic [2:0] s1, s2, nstep;
    logic [7:0] nbyte;
    logic [7:0] icw1, icw2, icw3, icw4, mask;
    logic       eoi_pend;
    assign rd_n = 1'b1;
    always_comb begin
        s1    = step + 3'd1;
        s2    = (s1 == 3'd2 && icw1[1]) ? 3'd3 : s1;
        nstep = (s2 == 3'd3 && !icw1[0]) ? 3'd4 : s2;
        nbyte = nstep == 3'd1 ? icw2 : nstep == 3'd2 ? icw3 : nstep == 3'd3 ? icw4 : mask;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            step         <= 3'd0;
            eoi_pend     <= 1'b0;
            cs_n         <= 1'b1;
            wr_n         <= 1'b1;
            a0           <= 1'b0;
            data_out     <= 8'd0;
            data_oe      <= 1'b0;
            int_ack_n    <= 1'b1;
            vector       <= 8'd0;
            vector_valid <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            icw1         <= 8'd0;
            icw2         <= 8'd0;
            icw3         <= 8'd0;
            icw4         <= 8'd0;
            mask         <= 8'd0;
        end else begin
            vector_valid <= 1'b0;
            if (eoi_req && state != IDLE) eoi_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_init) begin
                        icw1      <= cfg_icw1;
                        icw2      <= cfg_icw2;
                        icw3      <= cfg_icw3;
                        icw4      <= cfg_icw4;
                        mask      <= cfg_mask;
                        step      <= 3'd0;
                        state     <= W_SETUP;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        data_oe   <= 1'b1;
                        a0        <= 1'b0;
                        data_out  <= cfg_icw1 | 8'h10;
                        init_done <= 1'b0;
                        eoi_pend  <= eoi_pend | eoi_req;
                    end else if (eoi_pend || eoi_req) begin
                        step     <= 3'd5;
                        state    <= W_SETUP;
                        busy     <= 1'b1;
                        cs_n     <= 1'b0;
                        data_oe  <= 1'b1;
                        a0       <= 1'b0;
                        data_out <= 8'h20;
                        eoi_pend <= 1'b0;
                    end else if (pic_int && init_done) begin
                        state     <= A1_LOW;
                        busy      <= 1'b1;
                        int_ack_n <= 1'b0;
                        cnt       <= 8'd0;
                    end
                end
                W_SETUP: begin
                    state <= W_STROBE;
                    wr_n  <= 1'b0;
                    cnt   <= 8'd0;
                end
                W_STROBE: begin
                    if (cnt == 8'(WR_PULSE - 1)) begin
                        state <= W_HOLD;
                        wr_n  <= 1'b1;
                    end else cnt <= cnt + 8'd1;
                end
                W_HOLD: begin
                    if (step >= 3'd4) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cs_n    <= 1'b1;
                        data_oe <= 1'b0;
                        if (step == 3'd4) init_done <= 1'b1;
                    end else begin
                        state    <= W_SETUP;
                        step     <= nstep;
                        a0       <= 1'b1;
                        data_out <= nbyte;
                    end
                end
                A1_LOW: begin
                    if (cnt == 8'(INTA_PULSE - 1)) begin
                        state     <= A_GAP;
                        int_ack_n <= 1'b1;
                        cnt       <= 8'd0;
                    end else cnt <= cnt + 8'd1;
                end
                A_GAP: begin
                    if (cnt == 8'(INTA_GAP - 1)) begin
                        state     <= A2_LOW;
                        int_ack_n <= 1'b0;
                        cnt       <= 8'd0;
                    end else cnt <= cnt + 8'd1;
                end
                A2_LOW: begin
                    if (cnt == 8'(INTA_PULSE - 1)) begin
                        state        <= A_END;
                        int_ack_n    <= 1'b1;
                        vector       <= data_in;
                        vector_valid <= 1'b1;
                    end else cnt <= cnt + 8'd1;
                end
                A_END: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef PIC_HOST_AUTO_EOI_EN
                    eoi_pend <= 1'b1;
`else
                    eoi_pend <= eoi_pend | eoi_req;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
